gate_identifier: RTL
====================

Name: gate_identifier

Overview:
- Characterises an unknown 2-input logic gate under test (GUT).
- Drives the GUT inputs through all four combinations and samples the GUT output for each one.
- Assembles a 4-bit truth table and decodes it to a gate code: 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR.
- Lab-level stimulus/checker block that sits on the other side of any basic gate cell in the lab designs.

Parameters:
- SETTLE_CYCLES, 2, extra clock cycles each input combination is held before sampling; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous reset, active-high
- start  input  1  single-cycle request to begin a sweep
- z_in  input  1  GUT output, assumed settled within SETTLE_CYCLES
- a_out  output  1  GUT input A
- b_out  output  1  GUT input B
- busy  output  1  high while a sweep is in progress
- done  output  1  one-cycle pulse when results update
- valid  output  1  truth table matched a known gate
- gate_code  output  3  decoded gate; 3'b111 when unrecognised
- truth_table  output  4  bit index = {A,B}; bit value = sampled z_in

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, rst.
- All outputs are registered.
- Reset values: a_out=0, b_out=0, busy=0, done=0, valid=0, gate_code=3'b111, truth_table=4'b0000.
- rst overrides everything, including mid-sweep. A sweep in progress is abandoned with no done pulse, and the FSM returns to IDLE.
- States: IDLE, DRIVE, DECODE.
- IDLE:
  - a_out/b_out = 00, busy=0.
  - start=1 sampled at edge E: next state DRIVE, busy=1, combo index i=0, hold counter=0.
- DRIVE:
  - {a_out,b_out} = i, in order 00, 01, 10, 11.
  - Each combination is held for exactly SETTLE_CYCLES+1 cycles.
  - z_in is captured into shadow bit i on the edge that ends the final hold cycle of combination i.
  - The counter then clears and i increments. After i=3 is captured, next state DECODE.
- DECODE (1 cycle):
  - busy stays 1. Shadow table is decoded combinationally.
  - On the exiting edge: truth_table, gate_code and valid register; done=1 for one cycle; busy=0; state IDLE; a_out/b_out=00.
- Latency: done is high in the cycle beginning 4*(SETTLE_CYCLES+1)+1 edges after E (13 cycles for the default).
- Decode table:
  - 1000 -> 0 (AND)
  - 0111 -> 1 (NAND)
  - 1110 -> 2 (OR)
  - 0001 -> 3 (NOR)
  - 0110 -> 4 (XOR)
  - 1001 -> 5 (XNOR)
  - any other -> gate_code=3'b111, valid=0; truth_table still reported.
- start while busy=1 is ignored (not queued).
- start high in the done cycle is accepted: back-to-back sweep, busy=1 next cycle.
- Results hold until the next done pulse or rst.

Optional Feature:
- Macro: GATE_IDENTIFIER_EXPECT_EN.
- Defined:
  - Adds input expected_code[2:0], sampled at the start edge and held for the sweep.
  - Adds registered output pass, reset 0, updated with done.
  - pass=1 iff valid=1 and gate_code equals the held expected value.
- Undefined: neither port exists; behaviour is otherwise identical.

Test Plan:
- Reset, then GUT=AND, start pulse (SETTLE_CYCLES=2):
  - a_out/b_out sequence 00,01,10,11, three cycles each.
  - done at +13 cycles; truth_table=1000, gate_code=0, valid=1.
- Sweep each of NAND/OR/NOR/XOR/XNOR back-to-back, start asserted in each done cycle:
  - codes 1,2,3,4,5 with tables 0111, 1110, 0001, 0110, 1001.
  - busy never drops for more than the done cycle.
- GUT output tied to 0:
  - truth_table=0000, gate_code=3'b111, valid=0.
- Extra start pulses at cycles 4 and 8 of a sweep:
  - single done at +13, results unaffected.
- rst asserted at cycle 6 of a sweep:
  - next cycle all outputs at reset values, no done pulse.
  - fresh start completes normally.
- With GATE_IDENTIFIER_EXPECT_EN defined: expected_code=4 with an XOR GUT gives pass=1; expected_code=4 with an XNOR GUT gives pass=0.

Source files
------------

// File: rtl/gate_identifier.sv
// rtl/gate_identifier.sv - sweeps a 2-input gate under test and decodes its truth table
// Optional expected-code check enabled by GATE_IDENTIFIER_EXPECT_EN.
module gate_identifier #(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       z_in,
`ifdef GATE_IDENTIFIER_EXPECT_EN
   input  logic [2:0] expected_code,
   output logic       pass,
`endif
   output logic       a_out,
   output logic       b_out,
   output logic       busy,
   output logic       done,
   output logic       valid,
   output logic [2:0] gate_code,
   output logic [3:0] truth_table
);

   typedef enum logic [1:0] {
      IDLE,
      DRIVE,
      DECODE
   } state_t;

   state_t     state_q, state_d;
   logic [1:0] idx_q, idx_d;
   logic [3:0] cnt_q, cnt_d;
   logic [3:0] shadow_q, shadow_d;
   logic [1:0] ab_q, ab_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       valid_q, valid_d;
   logic [2:0] code_q, code_d;
   logic [3:0] tt_q, tt_d;
   logic [2:0] dec_code;
   logic       dec_valid;
`ifdef GATE_IDENTIFIER_EXPECT_EN
   logic [2:0] exp_q, exp_d;
   logic       pass_q, pass_d;
`endif

   // Truth table bit index is {A,B}, so AND only sets bit 3.
   always_comb begin
      dec_code  = 3'b111;
      dec_valid = 1'b0;
      case (shadow_q)
         4'b1000: begin dec_code = 3'd0; dec_valid = 1'b1; end
         4'b0111: begin dec_code = 3'd1; dec_valid = 1'b1; end
         4'b1110: begin dec_code = 3'd2; dec_valid = 1'b1; end
         4'b0001: begin dec_code = 3'd3; dec_valid = 1'b1; end
         4'b0110: begin dec_code = 3'd4; dec_valid = 1'b1; end
         4'b1001: begin dec_code = 3'd5; dec_valid = 1'b1; end
         default: begin dec_code = 3'b111; dec_valid = 1'b0; end
      endcase
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      shadow_d = shadow_q;
      ab_d     = ab_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      valid_d  = valid_q;
      code_d   = code_q;
      tt_d     = tt_q;
`ifdef GATE_IDENTIFIER_EXPECT_EN
      exp_d    = exp_q;
      pass_d   = pass_q;
`endif
      case (state_q)
         IDLE: begin
            ab_d = 2'b00;
            if (start) begin
               state_d = DRIVE;
               busy_d  = 1'b1;
               idx_d   = 2'd0;
               cnt_d   = 4'd0;
`ifdef GATE_IDENTIFIER_EXPECT_EN
               exp_d   = expected_code;
`endif
            end
         end
         DRIVE: begin
            if (cnt_q == 4'(SETTLE_CYCLES)) begin
               shadow_d[idx_q] = z_in;
               cnt_d = 4'd0;
               if (idx_q == 2'd3) begin
                  state_d = DECODE;
               end else begin
                  idx_d = idx_q + 2'd1;
                  ab_d  = idx_q + 2'd1;
               end
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         DECODE: begin
            state_d = IDLE;
            tt_d    = shadow_q;
            code_d  = dec_code;
            valid_d = dec_valid;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            ab_d    = 2'b00;
`ifdef GATE_IDENTIFIER_EXPECT_EN
            pass_d  = dec_valid && (dec_code == exp_q);
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         idx_q    <= 2'd0;
         cnt_q    <= 4'd0;
         shadow_q <= 4'd0;
         ab_q     <= 2'b00;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         valid_q  <= 1'b0;
         code_q   <= 3'b111;
         tt_q     <= 4'd0;
`ifdef GATE_IDENTIFIER_EXPECT_EN
         exp_q    <= 3'd0;
         pass_q   <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         cnt_q    <= cnt_d;
         shadow_q <= shadow_d;
         ab_q     <= ab_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         valid_q  <= valid_d;
         code_q   <= code_d;
         tt_q     <= tt_d;
`ifdef GATE_IDENTIFIER_EXPECT_EN
         exp_q    <= exp_d;
         pass_q   <= pass_d;
`endif
      end
   end

   assign a_out       = ab_q[1];
   assign b_out       = ab_q[0];
   assign busy        = busy_q;
   assign done        = done_q;
   assign valid       = valid_q;
   assign gate_code   = code_q;
   assign truth_table = tt_q;
`ifdef GATE_IDENTIFIER_EXPECT_EN
   assign pass        = pass_q;
`endif

endmodule
